// File: rtl/lcd1602_drive_pkg.sv
// Shared types, HD44780 command bytes and character helpers for the LCD1602 driver.
package lcd_pkg;

  typedef enum logic [2:0] {
    POR   = 3'd0,
    INIT  = 3'd1,
    ADDR1 = 3'd2,
    LINE1 = 3'd3,
    ADDR2 = 3'd4,
    LINE2 = 3'd5
  } lcd_state_t;

  localparam logic [7:0] LCD_CMD_FUNCSET = 8'h38;
  localparam logic [7:0] LCD_CMD_DISPON  = 8'h0C;
  localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;
  localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
  localparam logic [7:0] LCD_CMD_LINE1   = 8'h80;
  localparam logic [7:0] LCD_CMD_LINE2   = 8'hC0;
  localparam logic [7:0] LCD_CHAR_SPACE  = 8'h20;

  localparam int LCD_NCHARS = 25;
  localparam int LCD_VEC_W  = LCD_NCHARS * 8;

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    logic [7:0] c;
    case (i)
      2'd0:    c = LCD_CMD_FUNCSET;
      2'd1:    c = LCD_CMD_DISPON;
      2'd2:    c = LCD_CMD_ENTRY;
      default: c = LCD_CMD_CLEAR;
    endcase
    return c;
  endfunction

  // Character k of the snapshot; positions beyond the supplied text pad with spaces.
  function automatic logic [7:0] lcd_byte(input logic [LCD_VEC_W-1:0] v, input logic [4:0] k);
    logic [7:0] b;
    b = LCD_CHAR_SPACE;
    if (k < 5'(LCD_NCHARS)) b = v[8*k +: 8];
    return b;
  endfunction

endpackage

// File: rtl/lcd1602_drive_step_timer.sv
// Bus step timer: free-running step counter with step-start pulse and enable-strobe window.
module lcd_step_timer #(
  parameter int STEP_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic step_start,
  output logic en_window
);

  localparam int SC_W = $clog2(STEP_CYC);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(STEP_CYC - 1);
  localparam logic [SC_W-1:0] EN_LO   = SC_W'(STEP_CYC / 4);
  localparam logic [SC_W-1:0] EN_HI   = SC_W'((3 * STEP_CYC) / 4);

  logic [SC_W-1:0] r_sc;

  always_ff @(posedge clk) begin
    if (rst)                  r_sc <= '0;
    else if (r_sc == SC_LAST) r_sc <= '0;
    else                      r_sc <= r_sc + 1'b1;
  end

  assign step_start = (r_sc == '0);
  assign en_window  = (r_sc >= EN_LO) && (r_sc < EN_HI);

endmodule

// File: rtl/lcd1602_drive.sv
// LCD1602 8-bit write-only driver: power-on wait, init, then continuous two-line refresh.
// Optional backlight PWM when LCD_BL_PWM_EN is defined.
module lcd1602_drive
  import lcd_pkg::*;
#(
  parameter int STEP_CYC  = 50000,
  parameter int POR_STEPS = 20,
  parameter int BL_DUTY   = 8
) (
  input  logic                 CLOCK_50,
  input  logic                 rst,
  input  logic [LCD_VEC_W-1:0] data_in,
  input  logic                 bl_in,
  output logic [7:0]           LCD_DATA,
  output logic                 LCD_RS,
  output logic                 LCD_RW,
  output logic                 LCD_EN,
  output logic                 LCD_ON,
  output logic                 LCD_BLON,
  output logic                 frame_done,
  output lcd_state_t           dbg_state
);

  localparam logic [7:0] POR_LAST = 8'(POR_STEPS);

  logic                 w_step_start;
  logic                 w_en_window;
  lcd_state_t           r_state;
  logic [7:0]           r_idx;
  logic [7:0]           r_data;
  logic                 r_rs;
  logic                 r_en;
  logic                 r_done;
  logic                 r_blon;
  logic [LCD_VEC_W-1:0] r_snap;

  lcd_step_timer #(.STEP_CYC(STEP_CYC)) u_timer (
    .clk        (CLOCK_50),
    .rst        (rst),
    .step_start (w_step_start),
    .en_window  (w_en_window)
  );

  // Each step-start edge chooses the byte presented for the whole step that follows.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      r_state <= POR;
      r_idx   <= '0;
      r_data  <= '0;
      r_rs    <= 1'b0;
      r_en    <= 1'b0;
      r_done  <= 1'b0;
      r_snap  <= '0;
    end else begin
      r_done <= 1'b0;
      r_en   <= w_en_window && (r_state != POR);
      if (w_step_start) begin
        case (r_state)
          POR: begin
            if (r_idx == POR_LAST) begin
              r_state <= INIT;
              r_idx   <= '0;
              r_data  <= init_cmd(2'd0);
              r_rs    <= 1'b0;
            end else begin
              r_idx <= r_idx + 8'd1;
            end
          end
          INIT: begin
            if (r_idx == 8'd3) begin
              r_state <= ADDR1;
              r_idx   <= '0;
              r_data  <= LCD_CMD_LINE1;
              r_rs    <= 1'b0;
              r_snap  <= data_in;
            end else begin
              r_idx  <= r_idx + 8'd1;
              r_data <= init_cmd(2'(r_idx + 8'd1));
            end
          end
          ADDR1: begin
            r_state <= LINE1;
            r_idx   <= '0;
            r_data  <= lcd_byte(r_snap, 5'd0);
            r_rs    <= 1'b1;
          end
          LINE1: begin
            if (r_idx == 8'd15) begin
              r_state <= ADDR2;
              r_idx   <= '0;
              r_data  <= LCD_CMD_LINE2;
              r_rs    <= 1'b0;
            end else begin
              r_idx  <= r_idx + 8'd1;
              r_data <= lcd_byte(r_snap, 5'(r_idx + 8'd1));
            end
          end
          ADDR2: begin
            r_state <= LINE2;
            r_idx   <= '0;
            r_data  <= lcd_byte(r_snap, 5'd16);
            r_rs    <= 1'b1;
          end
          LINE2: begin
            if (r_idx == 8'd15) begin
              r_state <= ADDR1;
              r_idx   <= '0;
              r_data  <= LCD_CMD_LINE1;
              r_rs    <= 1'b0;
              r_snap  <= data_in;
              r_done  <= 1'b1;
            end else begin
              r_idx  <= r_idx + 8'd1;
              r_data <= lcd_byte(r_snap, 5'(r_idx + 8'd17));
            end
          end
          default: begin
            r_state <= POR;
            r_idx   <= '0;
          end
        endcase
      end
    end
  end

`ifdef LCD_BL_PWM_EN
  // PWM counter wraps once per bus step; duty is BL_DUTY sixteenths.
  localparam int PDIV = ((STEP_CYC / 16) < 1) ? 1 : (STEP_CYC / 16);
  localparam logic [31:0] PDIV_LAST = 32'(PDIV - 1);
  localparam logic [4:0]  DUTY5     = 5'((BL_DUTY > 16) ? 16 : BL_DUTY);

  logic [31:0] r_pdiv;
  logic [3:0]  r_pc;
  logic        r_bl;

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      r_pdiv <= '0;
      r_pc   <= '0;
      r_bl   <= 1'b0;
      r_blon <= 1'b0;
    end else begin
      r_bl <= bl_in;
      if (r_pdiv == PDIV_LAST) begin
        r_pdiv <= '0;
        r_pc   <= r_pc + 4'd1;
      end else begin
        r_pdiv <= r_pdiv + 32'd1;
      end
      r_blon <= r_bl && ({1'b0, r_pc} < DUTY5);
    end
  end
`else
  always_ff @(posedge CLOCK_50) begin
    if (rst) r_blon <= 1'b0;
    else     r_blon <= bl_in;
  end
`endif

  assign LCD_DATA   = r_data;
  assign LCD_RS     = r_rs;
  assign LCD_RW     = 1'b0;
  assign LCD_EN     = r_en;
  assign LCD_ON     = 1'b1;
  assign LCD_BLON   = r_blon;
  assign frame_done = r_done;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_lcd1602_drive.sv
// Self-checking bench for lcd1602_drive with STEP_CYC=8, POR_STEPS=2, default (non-PWM) build.
module tb_lcd1602_drive;
  import lcd_pkg::*;

  localparam int STEP_CYC  = 8;
  localparam int POR_STEPS = 2;

  // Clock and DUT signals
  logic         clk = 1'b0;
  logic         rst;
  logic         bl_in;
  logic [199:0] data_in;
  logic [7:0]   LCD_DATA;
  logic         LCD_RS, LCD_RW, LCD_EN, LCD_ON, LCD_BLON, frame_done;
  lcd_state_t   dbg_state;

  always #5 clk = ~clk;

  lcd1602_drive #(.STEP_CYC(STEP_CYC), .POR_STEPS(POR_STEPS), .BL_DUTY(8)) dut (
    .CLOCK_50   (clk),
    .rst        (rst),
    .data_in    (data_in),
    .bl_in      (bl_in),
    .LCD_DATA   (LCD_DATA),
    .LCD_RS     (LCD_RS),
    .LCD_RW     (LCD_RW),
    .LCD_EN     (LCD_EN),
    .LCD_ON     (LCD_ON),
    .LCD_BLON   (LCD_BLON),
    .frame_done (frame_done),
    .dbg_state  (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int fd_cnt  = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (frame_done === 1'b1) fd_cnt++;

  typedef struct {
    logic [7:0] data;
    logic       rs;
  } vec_t;

  vec_t init_v[4];
  vec_t f1_v[34];
  vec_t f2_v[34];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits for the next LCD_EN strobe; reports latched byte, setup and width in cycles.
  task automatic get_strobe(output logic [7:0] d, output logic rs, output int setup,
                            output int width, output int chg_c, output int en_c);
    logic [7:0] prev;
    bit seen;
    prev = LCD_DATA; setup = 0; chg_c = cyc; en_c = cyc; width = 0; d = '0; rs = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clk);
      if (LCD_DATA !== prev) begin setup = 0; chg_c = cyc; end
      else setup++;
      prev = LCD_DATA;
      if (LCD_EN === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      chk("strobe_timeout", 32'd0, 32'd1);
      return;
    end
    d = LCD_DATA; rs = LCD_RS; en_c = cyc; width = 1;
    while (width < 50) begin
      @(negedge clk);
      if (LCD_EN !== 1'b1) break;
      width++;
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       rs;
    int         setup, width, chg_c, en_c, rcyc, t80, fdc;
    bit         got;

    init_v[0] = '{8'h38, 1'b0};
    init_v[1] = '{8'h0C, 1'b0};
    init_v[2] = '{8'h06, 1'b0};
    init_v[3] = '{8'h01, 1'b0};
    f1_v[0]  = '{8'h80, 1'b0};
    f1_v[17] = '{8'hC0, 1'b0};
    for (int c = 0; c < 16; c++) begin
      f1_v[1 + c]  = '{8'(8'h41 + c), 1'b1};
      f1_v[18 + c] = '{(c < 9) ? 8'(8'h51 + c) : 8'h20, 1'b1};
    end
    f2_v = f1_v;
    f2_v[1].data = 8'h5A;

    rst = 1'b1;
    bl_in = 1'b0;
    for (int k = 0; k < 25; k++) data_in[8*k +: 8] = 8'(8'h41 + k);

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_data", 32'(LCD_DATA), 32'h00);
    chk("rst_rs", 32'(LCD_RS), 32'd0);
    chk("rst_rw", 32'(LCD_RW), 32'd0);
    chk("rst_en", 32'(LCD_EN), 32'd0);
    chk("rst_on", 32'(LCD_ON), 32'd1);
    chk("rst_blon", 32'(LCD_BLON), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(POR));
    rcyc = cyc;
    rst = 1'b0;

    // Power-on wait and init commands
    for (int i = 0; i < 4; i++) begin
      get_strobe(d, rs, setup, width, chg_c, en_c);
      if (i == 0) begin
        chk("por_data_change_cyc", 32'(chg_c - rcyc), 32'd17);
        chk("por_first_en_cyc", 32'(en_c - rcyc), 32'd19);
      end
      chk($sformatf("init_data[%0d]", i), 32'(d), 32'(init_v[i].data));
      chk($sformatf("init_rs[%0d]", i), 32'(rs), 32'(init_v[i].rs));
      chk($sformatf("init_setup[%0d]", i), 32'(setup), 32'd2);
      chk($sformatf("init_width[%0d]", i), 32'(width), 32'd4);
    end

    // First frame; byte 0 changes mid-LINE1 and must not appear until next frame
    t80 = 0;
    for (int i = 0; i < 34; i++) begin
      get_strobe(d, rs, setup, width, chg_c, en_c);
      if (i == 0) t80 = chg_c;
      if (i == 5) data_in[7:0] = 8'h5A;
      chk($sformatf("f1_data[%0d]", i), 32'(d), 32'(f1_v[i].data));
      chk($sformatf("f1_rs[%0d]", i), 32'(rs), 32'(f1_v[i].rs));
      chk($sformatf("f1_width[%0d]", i), 32'(width), 32'd4);
    end

    got = 1'b0; fdc = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin got = 1'b1; fdc = cyc; end
    end
    chk("frame_done_seen", 32'(got), 32'd1);
    chk("frame_len_cycles", 32'(fdc - t80), 32'd272);

    // Backlight follows bl_in one cycle later
    chk("blon_before", 32'(LCD_BLON), 32'd0);
    bl_in = 1'b1;
    @(negedge clk);
    chk("blon_after", 32'(LCD_BLON), 32'd1);
    chk("frame_done_one_cycle", 32'(frame_done), 32'd0);

    // Second frame up to LINE2 col 6
    for (int i = 0; i < 25; i++) begin
      get_strobe(d, rs, setup, width, chg_c, en_c);
      chk($sformatf("f2_data[%0d]", i), 32'(d), 32'(f2_v[i].data));
      chk($sformatf("f2_rs[%0d]", i), 32'(rs), 32'(f2_v[i].rs));
    end

    // Reset while strobing LINE2 col 7
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (LCD_EN === 1'b1) got = 1'b1;
    end
    chk("en_before_rst", 32'(got), 32'd1);
    chk("data_before_rst", 32'(LCD_DATA), 32'h58);
    chk("blon_before_rst", 32'(LCD_BLON), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rcyc = cyc;
    rst = 1'b0;
    chk("midrst_en", 32'(LCD_EN), 32'd0);
    chk("midrst_data", 32'(LCD_DATA), 32'h00);
    chk("midrst_rs", 32'(LCD_RS), 32'd0);
    chk("midrst_blon", 32'(LCD_BLON), 32'd0);
    chk("midrst_state", 32'(dbg_state), 32'(POR));
    chk("frame_done_count", 32'(fd_cnt), 32'd1);

    get_strobe(d, rs, setup, width, chg_c, en_c);
    chk("restart_data", 32'(d), 32'h38);
    chk("restart_rs", 32'(rs), 32'd0);
    chk("restart_change_cyc", 32'(chg_c - rcyc), 32'd17);
    chk("restart_width", 32'(width), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd1602_drive.md
Name: lcd1602_drive

Overview:
- Downstream consumer of the LCD text/backlight formatter. Takes its 200-bit character vector `data_in` (25 ASCII bytes) and backlight request `bl_in`, and drives an HD44780-compatible LCD1602 in 8-bit, write-only mode.
- Runs power-on wait and init once, then refreshes both display lines continuously.
- Snapshots `data_in` once per frame so a display never tears mid-refresh.

Parameters:
- STEP_CYC, 50000: clock cycles per bus step (1 ms at 50 MHz); one command/data byte per step; minimum 8.
- POR_STEPS, 20: idle steps after reset before the first init command.
- BL_DUTY, 8: backlight PWM on-count out of 16 (only with LCD_BL_PWM_EN).

Ports:
- CLOCK_50  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- data_in  in  200  character bytes: byte k = data_in[8k+7:8k]; k=0..15 line 1 cols 0..15; k=16..24 line 2 cols 0..8.
- bl_in  in  1  backlight request.
- LCD_DATA  out  8  LCD data bus.
- LCD_RS  out  1  0 = command, 1 = character data.
- LCD_RW  out  1  constant 0 (write only).
- LCD_EN  out  1  enable strobe.
- LCD_ON  out  1  LCD power.
- LCD_BLON  out  1  backlight.
- frame_done  out  1  one-cycle pulse after the last byte of each refresh frame.

Behaviour:
Reset values (asserted in the cycle after rst is sampled high):
- LCD_DATA=0x00, LCD_RS=0, LCD_RW=0, LCD_EN=0, LCD_ON=1, LCD_BLON=0, frame_done=0.
- State=POR, step counter=0, byte index=0.
- Reset mid-operation aborts any step immediately and restarts from POR. There is no partial strobe: LCD_EN goes 0 in the same cycle.

Step timer:
- Counter sc runs 0..STEP_CYC-1 and wraps.
- At sc==0 the FSM advances and LCD_DATA/LCD_RS load the new byte. They are held for the whole step.
- LCD_EN=1 only while STEP_CYC/4 <= sc < 3*STEP_CYC/4 in INIT and REFRESH states. This gives setup and hold of at least STEP_CYC/4 on each side of the strobe.

FSM, one transition per step:
- POR: LCD_EN=0 for POR_STEPS steps, then go to INIT.
- INIT: commands 0x38, 0x0C, 0x06, 0x01 in that order, RS=0.
- ADDR1: cmd 0x80, RS=0. In the same cycle, the full 200-bit `data_in` is latched into `snap`.
- LINE1: 16 steps, RS=1, bytes snap[0..15].
- ADDR2: cmd 0xC0, RS=0.
- LINE2: 16 steps, RS=1. Bytes snap[16..24] for cols 0..8, then 0x20 (space) for cols 9..15.
- After the last LINE2 step completes, frame_done pulses for one cycle at the next sc==0 and the FSM goes to ADDR1.
- Frame length is 34 steps; the first frame starts POR_STEPS+4 steps after reset.
- Changes to `data_in` during a frame are ignored until the next ADDR1 latch.

Backlight:
- LCD_BLON is registered from bl_in, 1 cycle latency.

Optional Feature:
- Macro LCD_BL_PWM_EN.
- Defined: a free-running 4-bit counter pc increments every STEP_CYC/16 cycles (period = 1 step). LCD_BLON = bl_in_r & (pc < BL_DUTY), registered. BL_DUTY=16 means always on; BL_DUTY=0 means always off.
- Undefined: LCD_BLON = registered bl_in; BL_DUTY is ignored.

Decomposition:
- Shared package lcd_pkg:
  - state enum: POR, INIT, ADDR1, LINE1, ADDR2, LINE2.
  - command constants: LCD_CMD_FUNCSET=0x38, LCD_CMD_DISPON=0x0C, LCD_CMD_ENTRY=0x06, LCD_CMD_CLEAR=0x01, LCD_CMD_LINE1=0x80, LCD_CMD_LINE2=0xC0.
  - LCD_CHAR_SPACE=0x20.
  - LCD_NCHARS=25.
- One sub-module, lcd_step_timer: owns sc and outputs step_start (sc==0) and en_window.

Test Plan (STEP_CYC=8, POR_STEPS=2 unless stated):
- Reset, then idle → LCD_EN stays 0 for 16 cycles. Then 4 strobes with RS=0 and data 0x38, 0x0C, 0x06, 0x01. Each strobe is high for exactly 4 cycles, starting 2 cycles after the data changes.
- data_in with byte k = 0x41+k → at each LCD_EN rising edge the bench sees:
  - 0x80 (RS=0), then 0x41..0x50 (RS=1);
  - 0xC0 (RS=0), then 0x51..0x59, then seven 0x20 (RS=1);
  - frame_done pulses once, 34 steps = 272 cycles after the 0x80 step began.
- Change data_in byte 0 from 0x41 to 0x5A during LINE1 → the current frame still writes 0x41; the next frame writes 0x5A.
- Assert rst for 1 cycle mid-LINE2 while LCD_EN=1 → next cycle LCD_EN=0, LCD_DATA=0x00, LCD_BLON=0. The sequence restarts with POR, then 0x38.
- bl_in 0→1 → LCD_BLON=1 one cycle later (macro off).
- With LCD_BL_PWM_EN defined, STEP_CYC=32, BL_DUTY=4, bl_in=1 → LCD_BLON high 8 of every 32 cycles (a 4/16 duty cycle).
